// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: FSM encodings, parity modes
// and a parameter-legality check used at elaboration.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  function automatic bit uart_params_ok(input int clk_div, input int os,
                                        input int data_bits, input int stop_bits,
                                        input int parity_mode);
    return (clk_div >= 1) && (os >= 4) && ((os % 2) == 0) &&
           (data_bits >= 5) && (data_bits <= 9) &&
           ((stop_bits == 1) || (stop_bits == 2)) &&
           (parity_mode >= PAR_NONE) && (parity_mode <= PAR_ODD);
  endfunction

  // Upper payload bits are zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running oversample tick generator shared by the UART transmitter and
// receiver; tick is high for the one cycle the divider sits at CLK_DIV-1.
module uart_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 27
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_transceiver_param.sv
// Full-duplex parametrised UART (independent TX and RX FSMs, one shared tick).
// Optional parity bit generation/checking is built only when UART_PARITY_EN is defined.
module uart_transceiver_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV     = 27,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_MODE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  if (!uart_params_ok(CLK_DIV, OVERSAMPLE, DATA_BITS, STOP_BITS, PARITY_MODE)) begin : g_bad_params
    $error("uart_transceiver_param: illegal parameter set");
  end

  localparam int CW = $clog2(2 * OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] OS_LAST   = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * OVERSAMPLE - 1);
  localparam logic [BW-1:0] DB_LAST   = BW'(DATA_BITS - 1);
  localparam logic          SB_LAST   = 1'(STOP_BITS - 1);
`ifdef UART_PARITY_EN
  localparam bit PAR_ON = (PARITY_MODE != PAR_NONE);
`endif

  logic tick;

  uart_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // ---------------- transmitter ----------------
  tx_state_t            tx_state;
  logic [DATA_BITS-1:0] tx_shreg;
  logic [CW-1:0]        tx_os_cnt;
  logic [BW-1:0]        tx_bit_cnt;
  logic                 tx_armed;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state   <= TX_IDLE;
      tx_shreg   <= '0;
      tx_os_cnt  <= '0;
      tx_bit_cnt <= '0;
      tx_armed   <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par     <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (tx_start) begin
            tx_shreg  <= tx_data;
            tx_busy   <= 1'b1;
            tx_armed  <= 1'b1;
            tx_os_cnt <= '0;
            tx_state  <= TX_START;
`ifdef UART_PARITY_EN
            tx_par    <= parity_bit(9'(tx_data), PARITY_MODE);
`endif
          end
        end
        // tx_armed holds the line high until the first tick so every bit
        // cell is aligned to the shared tick grid.
        TX_START: begin
          if (tick) begin
            if (tx_armed) begin
              tx        <= 1'b0;
              tx_armed  <= 1'b0;
              tx_os_cnt <= '0;
            end else if (tx_os_cnt == OS_LAST) begin
              tx         <= tx_shreg[0];
              tx_shreg   <= tx_shreg >> 1;
              tx_bit_cnt <= '0;
              tx_os_cnt  <= '0;
              tx_state   <= TX_DATA;
            end else begin
              tx_os_cnt <= tx_os_cnt + 1'b1;
            end
          end
        end
        TX_DATA: begin
          if (tick) begin
            if (tx_os_cnt == OS_LAST) begin
              tx_os_cnt <= '0;
              if (tx_bit_cnt == DB_LAST) begin
`ifdef UART_PARITY_EN
                if (PAR_ON) begin
                  tx       <= tx_par;
                  tx_state <= TX_PARITY;
                end else begin
                  tx       <= 1'b1;
                  tx_state <= TX_STOP;
                end
`else
                tx       <= 1'b1;
                tx_state <= TX_STOP;
`endif
              end else begin
                tx         <= tx_shreg[0];
                tx_shreg   <= tx_shreg >> 1;
                tx_bit_cnt <= tx_bit_cnt + 1'b1;
              end
            end else begin
              tx_os_cnt <= tx_os_cnt + 1'b1;
            end
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (tick) begin
            if (tx_os_cnt == OS_LAST) begin
              tx_os_cnt <= '0;
              tx        <= 1'b1;
              tx_state  <= TX_STOP;
            end else begin
              tx_os_cnt <= tx_os_cnt + 1'b1;
            end
          end
        end
`endif
        TX_STOP: begin
          if (tick) begin
            if (tx_os_cnt == STOP_LAST) begin
              tx_os_cnt <= '0;
              tx_done   <= 1'b1;
              tx_busy   <= 1'b0;
              tx_state  <= TX_IDLE;
            end else begin
              tx_os_cnt <= tx_os_cnt + 1'b1;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic rx_meta;
  logic rx_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  rx_state_t            rx_state;
  logic [DATA_BITS-1:0] rx_shreg;
  logic [CW-1:0]        rx_os_cnt;
  logic [BW-1:0]        rx_bit_cnt;
  logic                 rx_stop_idx;
  logic                 rx_stop_bad;
`ifdef UART_PARITY_EN
  logic                 rx_par_bad;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state      <= RX_IDLE;
      rx_shreg      <= '0;
      rx_os_cnt     <= '0;
      rx_bit_cnt    <= '0;
      rx_stop_idx   <= 1'b0;
      rx_stop_bad   <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad    <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
      case (rx_state)
        RX_IDLE: begin
          if (tick && !rx_sync) begin
            rx_os_cnt <= '0;
            rx_state  <= RX_START;
          end
        end
        // Half a bit in: a line back high means the low was a glitch.
        RX_START: begin
          if (tick) begin
            if (rx_os_cnt == HALF_LAST) begin
              rx_os_cnt <= '0;
              if (rx_sync) begin
                rx_state <= RX_IDLE;
              end else begin
                rx_bit_cnt <= '0;
                rx_state   <= RX_DATA;
`ifdef UART_PARITY_EN
                rx_par_bad <= 1'b0;
`endif
              end
            end else begin
              rx_os_cnt <= rx_os_cnt + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (rx_os_cnt == OS_LAST) begin
              rx_os_cnt <= '0;
              rx_shreg  <= {rx_sync, rx_shreg[DATA_BITS-1:1]};
              if (rx_bit_cnt == DB_LAST) begin
                rx_stop_idx <= 1'b0;
                rx_stop_bad <= 1'b0;
`ifdef UART_PARITY_EN
                rx_state    <= PAR_ON ? RX_PARITY : RX_STOP;
`else
                rx_state    <= RX_STOP;
`endif
              end else begin
                rx_bit_cnt <= rx_bit_cnt + 1'b1;
              end
            end else begin
              rx_os_cnt <= rx_os_cnt + 1'b1;
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (tick) begin
            if (rx_os_cnt == OS_LAST) begin
              rx_os_cnt  <= '0;
              rx_par_bad <= (rx_sync != parity_bit(9'(rx_shreg), PARITY_MODE));
              rx_state   <= RX_STOP;
            end else begin
              rx_os_cnt <= rx_os_cnt + 1'b1;
            end
          end
        end
`endif
        RX_STOP: begin
          if (tick) begin
            if (rx_os_cnt == OS_LAST) begin
              rx_os_cnt <= '0;
              if (rx_stop_idx == SB_LAST) begin
                rx_data      <= rx_shreg;
                rx_valid     <= 1'b1;
                rx_frame_err <= rx_stop_bad | ~rx_sync;
`ifdef UART_PARITY_EN
                rx_parity_err <= PAR_ON & rx_par_bad;
`endif
                rx_state     <= (rx_stop_bad | ~rx_sync) ? RX_BREAK : RX_IDLE;
              end else begin
                rx_stop_bad <= rx_stop_bad | ~rx_sync;
                rx_stop_idx <= 1'b1;
              end
            end else begin
              rx_os_cnt <= rx_os_cnt + 1'b1;
            end
          end
        end
        // A held-low line reports one framing error, then waits for idle.
        RX_BREAK: begin
          if (rx_sync) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

`ifndef UART_PARITY_EN
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_transceiver_param.md
Name: uart_transceiver_param

Overview:
- Parametrised full-duplex UART: shared oversampling tick generator, transmitter and receiver in one block.
- Successor to the fixed 8N1 transmitter/receiver pair with separate baud generators.
- Adds configurable data width, parity, stop bits and divisor, plus framing/parity error reporting and start-bit glitch rejection.
- Sits between the AES core's byte interface and the board serial pins.

Parameters:
- CLK_DIV, 27: clk cycles per oversample tick (>=1).
- OVERSAMPLE, 16: ticks per bit period. Even, >=4.
- DATA_BITS, 8: payload bits per frame, 5..9.
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- PARITY_MODE, 0: 0 none, 1 even, 2 odd. Only used when UART_PARITY_EN is defined.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- tx_start  in  1  request to send tx_data; sampled on clk.
- tx_data  in  DATA_BITS  payload to transmit.
- tx_busy  out  1  high from accept to end of last stop bit.
- tx_done  out  1  one-cycle pulse when frame transmission completes.
- tx  out  1  serial output, idle high.
- rx  in  1  serial input, asynchronous.
- rx_data  out  DATA_BITS  last received payload; holds until next frame.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- rx_frame_err  out  1  one-cycle pulse with rx_valid if any stop bit sampled 0.
- rx_parity_err  out  1  one-cycle pulse with rx_valid on parity mismatch.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high, port reset.
  - Reset values: tx=1; tx_busy, tx_done, rx_valid, rx_frame_err, rx_parity_err =0; rx_data=0.
  - All counters and FSMs return to IDLE. Reset mid-frame aborts the frame immediately; tx returns high on the next edge.
- Tick generator:
  - Counter 0..CLK_DIV-1; tick asserted the cycle count==CLK_DIV-1, then wraps to 0.
  - Free-running and shared by TX and RX.
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - In IDLE, tx_start=1 latches tx_data. tx_busy rises on the next edge; tx drops to 0 on the first tick.
  - Each bit lasts exactly OVERSAMPLE ticks. Data is sent LSB first.
  - PARITY state is skipped when parity is disabled.
  - STOP lasts STOP_BITS*OVERSAMPLE ticks with tx=1.
  - tx_done pulses for one clk on the last stop tick; tx_busy falls the same edge.
  - tx_start while busy is ignored and does not queue.
  - tx_start coincident with tx_done is ignored; it may be re-asserted from the next cycle.
- RX FSM (IDLE, START, DATA, PARITY, STOP, BREAK):
  - rx passes through a 2-flop synchroniser (2 clk latency) before any use.
  - IDLE: synchronised rx=0 on a tick enters START.
  - START: after OVERSAMPLE/2 ticks, re-sample. If 1 it is a glitch: return to IDLE with no outputs. If 0, go to DATA.
  - DATA: sample every OVERSAMPLE ticks (mid-bit), shifting LSB first.
  - PARITY: sample one bit, compare with the computed parity.
  - STOP: sample each stop bit mid-bit.
  - After the last stop sample, in the same cycle: rx_data updated, rx_valid pulses, error flags pulse if applicable.
  - If any stop bit is 0, enter BREAK and wait for synchronised rx=1 before IDLE. A long low line produces exactly one frame error, not repeated frames.
- TX and RX are fully independent; simultaneous activity is required to work (loopback).

Optional Feature:
- Macro UART_PARITY_EN.
- Defined: PARITY_MODE is honoured. TX inserts the parity bit after the data bits. RX checks it and pulses rx_parity_err on mismatch; rx_valid still pulses and rx_data still updates.
- Undefined: no parity logic is synthesised, PARITY states are absent, frames never carry a parity bit, and rx_parity_err is tied 0.

Decomposition:
- Shared package uart_pkg:
  - TX and RX state encodings.
  - Parity mode constants (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2).
  - Parameter-legality check function.
- One natural sub-module: uart_tick_gen (divisor counter, tick output, parameter CLK_DIV). Instantiated once, shared by both FSMs.

Test Plan:
- Loopback 8N1: CLK_DIV=4, OVERSAMPLE=16, tx wired to rx, send 0x95.
  - rx_valid after about 640 clk, rx_data=0x95, no error flags.
  - tx_done pulses once; tx_busy high 640 +/-4 clk.
- Back-to-back: send 0x95 then 0xCD, the second tx_start 1 cycle after tx_done.
  - Both received in order.
  - tx_start asserted mid-frame is ignored: exactly 2 rx_valid pulses.
- Glitch: drive rx low for 3 ticks (less than OVERSAMPLE/2), then high.
  - No rx_valid; RX back in IDLE.
  - A following valid 0x3C frame is received correctly.
- Framing error: drive a frame 0xA5 with stop bit 0, then hold rx low for 5 bit-times, then release.
  - Exactly one rx_valid with rx_frame_err=1 and rx_data=0xA5.
  - No further frames until the line returns high.
- Parity (UART_PARITY_EN, PARITY_MODE=1, DATA_BITS=7):
  - Send 0x55: parity bit on tx is 0, rx_parity_err=0.
  - Inject a frame with flipped parity: rx_parity_err=1 and rx_data still 0x55.
- Reset mid-frame: assert reset during DATA of a TX frame.
  - tx=1 and tx_busy=0 one edge later.
  - No tx_done; a subsequent 0x81 frame is transmitted and received cleanly.
